sort4_sequencer: RTL and testbench
==================================

Name: sort4_sequencer

Overview:
- Collects a burst of N unsigned W-bit samples over a valid/ready input stream.
- Sorts the samples in place, ascending, using a single shared compare-and-swap datapath (gt/lt/eq relations) that runs one comparison per clock.
- Streams the sorted burst out over a valid/ready output stream.
- Sits between a sample producer and any consumer that needs ordered data (min/max/median extraction).

Parameters:
- N, 4, number of samples per burst; must be ≥2.
- W, 4, sample width in bits; samples are unsigned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a sample on in_data.
- in_data  input  W  input sample.
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  sorted sample available on out_data.
- out_data  output  W  sorted sample.
- out_last  output  1  marks the final (largest) sample of a burst.
- out_ready  input  1  consumer accepts the sample this cycle.
- busy  output  1  high while sorting.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - rst sampled high → state=LOAD, wr_cnt=0, rd_cnt=0, pass=0, idx=0, all buffer entries=0.
  - While rst is high: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0.
  - Reset mid-burst, mid-sort or mid-drain discards all data. No partial output follows.
- Handshake (both streams): a transfer occurs only on a cycle with valid && ready. valid must not depend combinationally on ready.
- State LOAD:
  - in_ready=1.
  - On each in_valid && in_ready: buf[wr_cnt] ← in_data, then wr_cnt++.
  - On the N-th accept: wr_cnt ← 0, go to SORT.
  - Gaps in in_valid are allowed.
- State SORT:
  - busy=1, in_ready=0, out_valid=0.
  - Bubble sort. Each cycle the block compares buf[idx] against buf[idx+1]:
    - gt → swap the two entries;
    - lt or eq → no change. Sort is stable; equal values are never swapped.
  - idx runs 0..N-2 for each pass. Passes run 0..N-2.
  - Latency is fixed at (N-1)*(N-1) cycles (9 for N=4). There is no early exit.
  - After the last compare: go to DRAIN, rd_cnt ← 0.
- State DRAIN:
  - out_valid=1, out_data=buf[rd_cnt], out_last=(rd_cnt==N-1).
  - On out_ready: rd_cnt++.
  - On the transfer with out_last: go to LOAD, rd_cnt ← 0.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - in_ready=0 throughout DRAIN. There is no overlap between bursts.
- Outputs are registered or decoded from state and counters. There is no combinational path from in_* to out_*.
- Timing: N-th input accepted at edge T → SORT covers edges T+1..T+(N-1)^2 → out_valid first high in the cycle after edge T+(N-1)^2 (T+10 for N=4).
- Counter widths: wr_cnt, rd_cnt and idx are $clog2(N) bits; pass is $clog2(N-1) bits, minimum 1 bit. Compares are unsigned, full W bits.

Decomposition:
- Shared package sort_pkg holds:
  - state enum {S_LOAD, S_SORT, S_DRAIN};
  - defaults for N and W;
  - a localparam function for the sort-cycle count (N-1)^2.
- One sub-module, sort_cmp_swap: combinational unit taking a and b (W bits each) and producing gt, lt, eq, lo=min(a,b), hi=max(a,b). The top instantiates it once, muxes buf[idx]/buf[idx+1] in, and writes lo/hi back.

Test Plan:
- Reversed input: load 9,7,3,1 with back-to-back in_valid → after 9 busy cycles out stream 1,3,7,9. out_last only on 9. Six swaps occur.
- Already sorted with duplicates: 2,5,5,15 → out 2,5,5,15. busy exactly 9 cycles. No swap enable ever asserted.
- Boundary values: 15,0,15,0 → out 0,0,15,15.
- Backpressure: inputs 4,1,3,2; out_ready toggles 0,1,0,0,1,... → out 1,2,3,4. out_data is unchanged during every stall. in_ready stays 0 until the 4 is accepted, then rises the next cycle.
- Input gaps and reset:
  - in_valid gaps between samples → wr_cnt advances only on handshakes; result is still correct.
  - rst for 1 cycle during SORT (after 3 compares) → next cycle in_ready=1, out_valid=0. A new burst 8,6,4,2 then yields 2,4,6,8 with no stale data.
- Consecutive bursts: burst A 3,3,1,2 then burst B 0,15,7,7, each started right after the prior out_last → out 1,2,3,3 then 0,7,7,15. First input of B is accepted in the cycle after A's out_last handshake.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and defaults for the burst sorter.
// Holds the sequencer state encoding and the sort-latency helper.
package sort_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_DRAIN
  } state_t;

  function automatic int sort_cycles(input int n);
    return (n - 1) * (n - 1);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-and-swap cell.
// Reports the a/b relation and returns the ordered pair.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  assign gt = a > b;
  assign lt = a < b;
  assign eq = a == b;
  assign lo = gt ? b : a;
  assign hi = gt ? a : b;

endmodule

// File: rtl/sort4_sequencer.sv
// Load / bubble-sort / drain sequencer for one burst of N samples.
// A single compare-and-swap cell is time-shared across all passes.
module sort4_sequencer
  import sort_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam int PW = (N > 2) ? $clog2(N - 1) : 1;

  state_t          state;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   rd_cnt;
  logic [CW-1:0]   idx;
  logic [CW-1:0]   idx_nx;
  logic [PW-1:0]   pass;
  logic [W-1:0]    mem [N];

  logic            gt;
  logic            lt;
  logic            eq;
  logic [W-1:0]    lo;
  logic [W-1:0]    hi;
  logic            swap_en;

  assign idx_nx = idx + 1'b1;

  sort_cmp_swap #(.W(W)) u_cmp (
    .a  (mem[idx]),
    .b  (mem[idx_nx]),
    .gt (gt),
    .lt (lt),
    .eq (eq),
    .lo (lo),
    .hi (hi)
  );

  // equal values stay put so the sort remains stable
  assign swap_en = (state == S_SORT) & gt & ~(lt | eq);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_LOAD;
      wr_cnt <= '0;
      rd_cnt <= '0;
      idx    <= '0;
      pass   <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            mem[wr_cnt] <= in_data;
            if (wr_cnt == CW'(N - 1)) begin
              wr_cnt <= '0;
              state  <= S_SORT;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        S_SORT: begin
          if (swap_en) begin
            mem[idx]    <= lo;
            mem[idx_nx] <= hi;
          end
          if (idx == CW'(N - 2)) begin
            idx <= '0;
            if (pass == PW'(N - 2)) begin
              pass   <= '0;
              rd_cnt <= '0;
              state  <= S_DRAIN;
            end else begin
              pass <= pass + 1'b1;
            end
          end else begin
            idx <= idx_nx;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (rd_cnt == CW'(N - 1)) begin
              rd_cnt <= '0;
              state  <= S_LOAD;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = !rst && (state == S_LOAD);
  assign busy      = !rst && (state == S_SORT);
  assign out_valid = !rst && (state == S_DRAIN);
  assign out_data  = out_valid ? mem[rd_cnt] : '0;
  assign out_last  = out_valid && (rd_cnt == CW'(N - 1));

endmodule

// File: tb/tb_sort4_sequencer.sv
// Scoreboard bench for sort4_sequencer.
// Driver pushes sorted expectations; monitor pops on each output transfer.
module tb_sort4_sequencer;
  import sort_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  typedef logic [W-1:0] burst_t [N];
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   pat_i = 0;
  logic pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  sort4_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // reference: repeatedly extract the smallest remaining sample
  task automatic push_exp(input burst_t v);
    int   rem[$];
    int   m;
    exp_t e;
    foreach (v[i]) rem.push_back(int'(v[i]));
    for (int k = 0; k < N; k++) begin
      m = 0;
      for (int j = 1; j < rem.size(); j++)
        if (rem[j] < rem[m]) m = j;
      e.d = W'(rem[m]);
      e.l = (k == N - 1);
      sb.push_back(e);
      rem.delete(m);
    end
  endtask

  task automatic send(input burst_t v, input int maxgap);
    logic acc;
    int   n;
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = v[i];
      n = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 300);
      if (!acc) chk("in_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic burst(input burst_t v, input int maxgap);
    push_exp(v);
    send(v, maxgap);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = pat[pat_i];
          pat_i = (pat_i + 1) % 5;
        end
      endcase
    end
  end

  int           busy_cnt = 0;
  int           acc_n = 0;
  int           acc_cyc = 0;
  logic         lat_arm = 1'b0;
  logic         held_v = 1'b0;
  logic [W-1:0] held_d = '0;
  logic         held_l = 1'b0;
  logic         after_last = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt   = 0;
      acc_n      = 0;
      lat_arm    = 1'b0;
      held_v     = 1'b0;
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        chk("in_ready_after_last", int'(in_ready), 1);
        after_last = 1'b0;
      end
      if (busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        chk("busy_cycles", busy_cnt, (N - 1) * (N - 1));
        busy_cnt = 0;
      end
      if (out_valid && lat_arm) begin
        chk("latency", cyc - acc_cyc, (N - 1) * (N - 1));
        lat_arm = 1'b0;
      end
      if (held_v) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(held_d));
        chk("stall_last", int'(out_last), int'(held_l));
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (out_valid && out_ready) begin
        chk("no_overlap_in_ready", int'(in_ready), 0);
        if (sb.size() == 0) begin
          chk("unexpected_output", int'(out_data), -1);
        end else begin
          e = sb.pop_front();
          chk("out_data", int'(out_data), int'(e.d));
          chk("out_last", int'(out_last), int'(e.l));
        end
        after_last = out_last;
      end
      if (in_valid && in_ready) begin
        acc_n++;
        if (acc_n == N) begin
          acc_n   = 0;
          lat_arm = 1'b1;
          acc_cyc = cyc + 1;
        end
      end
    end
  end

  initial begin
    burst_t v;
    int     n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    rdy_mode = 0;
    burst('{4'd9, 4'd7, 4'd3, 4'd1}, 0);
    burst('{4'd2, 4'd5, 4'd5, 4'd15}, 0);
    burst('{4'd15, 4'd0, 4'd15, 4'd0}, 0);
    burst('{4'd5, 4'd2, 4'd9, 4'd1}, 3);
    while (!in_ready) @(posedge clk);
    #1;
    rdy_mode = 2;
    pat_i    = 0;
    burst('{4'd4, 4'd1, 4'd3, 4'd2}, 0);

    rdy_mode = 0;
    send('{4'd11, 4'd10, 4'd12, 4'd13}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midsort_rst_busy", int'(busy), 0);
    chk("midsort_rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", int'(in_ready), 1);
    chk("after_rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    burst('{4'd8, 4'd6, 4'd4, 4'd2}, 0);

    burst('{4'd3, 4'd3, 4'd1, 4'd2}, 0);
    burst('{4'd0, 4'd15, 4'd7, 4'd7}, 0);

    repeat (20) begin
      rdy_mode = $urandom_range(0, 2);
      foreach (v[i]) v[i] = W'($urandom);
      burst(v, $urandom_range(0, 2));
    end

    rdy_mode = 0;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("pending_outputs", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
